// File: rtl/count_sequencer.sv
// count_sequencer: run-control sequencer driving a two-digit BCD counter with a divided count tick
// Optional feature macro: COUNT_SEQ_DOWN_EN (adds down-counting selected by dir_i latched on start)
// Ports:
//   clk_i      system clock, rising edge
//   rst_i      asynchronous active-high reset
//   start_i    one-cycle pulse: begin/resume counting
//   stop_i     one-cycle pulse: pause counting
//   clear_i    one-cycle pulse: return to idle, zero the count
//   dir_i      0 = up, 1 = down (ignored unless COUNT_SEQ_DOWN_EN)
//   ones_o     BCD ones digit
//   tens_o     BCD tens digit
//   running_o  high while in RUN
//   done_o     one-cycle pulse after entering DONE
module count_sequencer #(
  parameter int TICK_DIV = 50000000,
  parameter int TERM     = 99
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       clear_i,
  input  logic       dir_i,
  output logic [3:0] ones_o,
  output logic [3:0] tens_o,
  output logic       running_o,
  output logic       done_o
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
  localparam logic [3:0] TERM_T = 4'(TERM / 10);
  localparam logic [3:0] TERM_O = 4'(TERM % 10);
  state_t state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0] ones_q, ones_d, tens_q, tens_d, step_o, step_t, up_o, up_t, end_o, end_t;
  logic dir_q, load_dir, running_q, done_q, tick, load, at_end;
  // Stop outranks Start, Clear outranks both.
  assign load = !clear_i && start_i && !stop_i && (state_q == IDLE || state_q == DONE);
  assign tick = state_q == RUN && div_q == DIV_MAX;
  assign up_o = ones_q == 4'd9 ? 4'd0 : ones_q + 4'd1;
  assign up_t = ones_q == 4'd9 ? tens_q + 4'd1 : tens_q;
`ifdef COUNT_SEQ_DOWN_EN
  logic [3:0] dn_o, dn_t;
  assign dn_o = ones_q == 4'd0 ? 4'd9 : ones_q - 4'd1;
  assign dn_t = ones_q == 4'd0 ? tens_q - 4'd1 : tens_q;
  assign load_dir = dir_i;
  assign step_o = dir_q ? dn_o : up_o;
  assign step_t = dir_q ? dn_t : up_t;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) dir_q <= 1'b0;
    else if (load) dir_q <= dir_i;
`else
  logic unused_dir;
  assign unused_dir = dir_i;
  assign load_dir = 1'b0;
  assign dir_q = 1'b0;
  assign step_o = up_o;
  assign step_t = up_t;
`endif
  assign end_o = dir_q ? 4'd0 : TERM_O;
  assign end_t = dir_q ? 4'd0 : TERM_T;
  assign at_end = step_o == end_o && step_t == end_t;
  always_comb begin
    state_d = state_q;
    div_d = div_q;
    ones_d = ones_q;
    tens_d = tens_q;
    if (clear_i) begin
      state_d = IDLE;
      div_d = '0;
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (load) begin
      state_d = RUN;
      div_d = '0;
      ones_d = load_dir ? TERM_O : 4'd0;
      tens_d = load_dir ? TERM_T : 4'd0;
    end else if (state_q == RUN) begin
      // The divider keeps running on the Stop edge so that a later resume stays in phase.
      div_d = tick ? '0 : div_q + DW'(1);
      ones_d = tick ? step_o : ones_q;
      tens_d = tick ? step_t : tens_q;
      state_d = tick && at_end ? DONE : stop_i ? PAUSE : RUN;
    end else if (state_q == PAUSE && start_i && !stop_i) begin
      state_d = RUN;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      div_q <= '0;
      ones_q <= 4'd0;
      tens_q <= 4'd0;
      running_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      ones_q <= ones_d;
      tens_q <= tens_d;
      running_q <= state_d == RUN;
      done_q <= state_d == DONE && state_q != DONE;
    end
  assign ones_o = ones_q;
  assign tens_o = tens_q;
  assign running_o = running_q;
  assign done_o = done_q;
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed self-checking bench for count_sequencer with TICK_DIV=4, TERM=12
module tb_count_sequencer;
  logic clk = 1'b0, rst_i = 1'b1, start_i = 1'b0, stop_i = 1'b0, clear_i = 1'b0, dir_i = 1'b0;
  logic [3:0] ones_o, tens_o;
  logic running_o, done_o;
  int total = 0, bad = 0;
  count_sequencer #(.TICK_DIV(4), .TERM(12)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i),
    .dir_i(dir_i), .ones_o(ones_o), .tens_o(tens_o), .running_o(running_o), .done_o(done_o)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic s, input logic p, input logic c);
    start_i = s;
    stop_i = p;
    clear_i = c;
    cyc(1);
    start_i = 1'b0;
    stop_i = 1'b0;
    clear_i = 1'b0;
  endtask
  task automatic test_reset;
    cyc(2);
    total++;
    if ({tens_o, ones_o, running_o, done_o} !== 10'h0) begin
      bad++;
      $display("FAIL reset_hold got=%h want=000", {tens_o, ones_o, running_o, done_o});
    end
    rst_i = 1'b0;
    cyc(1);
    pulse(1'b0, 1'b1, 1'b0);
    total++;
    if (running_o !== 1'b0) begin
      bad++;
      $display("FAIL idle_stop_ignored running got=%b want=0", running_o);
    end
  endtask
  task automatic test_count_up;
    pulse(1'b1, 1'b0, 1'b0);
    total++;
    if ({tens_o, ones_o} !== 8'h00 || running_o !== 1'b1) begin
      bad++;
      $display("FAIL up_e0 got=%h run=%b want=00 run=1", {tens_o, ones_o}, running_o);
    end
    cyc(3);
    total++;
    if ({tens_o, ones_o} !== 8'h00) begin
      bad++;
      $display("FAIL up_e3 got=%h want=00", {tens_o, ones_o});
    end
    cyc(1);
    total++;
    if ({tens_o, ones_o} !== 8'h01) begin
      bad++;
      $display("FAIL up_e4 got=%h want=01", {tens_o, ones_o});
    end
    cyc(32);
    total++;
    if ({tens_o, ones_o} !== 8'h09) begin
      bad++;
      $display("FAIL up_e36 got=%h want=09", {tens_o, ones_o});
    end
    cyc(4);
    total++;
    if (tens_o !== 4'd1 || ones_o !== 4'd0) begin
      bad++;
      $display("FAIL bcd_carry got=%h want=10", {tens_o, ones_o});
    end
    cyc(4);
    total++;
    if ({tens_o, ones_o} !== 8'h11 || done_o !== 1'b0 || running_o !== 1'b1) begin
      bad++;
      $display("FAIL up_e44 got=%h done=%b run=%b want=11 done=0 run=1", {tens_o, ones_o}, done_o, running_o);
    end
    cyc(4);
    total++;
    if ({tens_o, ones_o} !== 8'h12 || done_o !== 1'b1 || running_o !== 1'b0) begin
      bad++;
      $display("FAIL up_e48 got=%h done=%b run=%b want=12 done=1 run=0", {tens_o, ones_o}, done_o, running_o);
    end
    cyc(1);
    total++;
    if (done_o !== 1'b0) begin
      bad++;
      $display("FAIL done_one_cycle got=%b want=0", done_o);
    end
    cyc(12);
    total++;
    if ({tens_o, ones_o} !== 8'h12 || running_o !== 1'b0) begin
      bad++;
      $display("FAIL done_hold got=%h run=%b want=12 run=0", {tens_o, ones_o}, running_o);
    end
  endtask
  task automatic test_restart_from_done;
    pulse(1'b1, 1'b0, 1'b0);
    total++;
    if ({tens_o, ones_o} !== 8'h00 || running_o !== 1'b1) begin
      bad++;
      $display("FAIL done_restart got=%h run=%b want=00 run=1", {tens_o, ones_o}, running_o);
    end
    cyc(4);
    total++;
    if ({tens_o, ones_o} !== 8'h01) begin
      bad++;
      $display("FAIL done_restart_step got=%h want=01", {tens_o, ones_o});
    end
    pulse(1'b0, 1'b0, 1'b1);
  endtask
  task automatic test_pause;
    pulse(1'b1, 1'b0, 1'b0);
    cyc(8);
    pulse(1'b0, 1'b1, 1'b0);
    total++;
    if ({tens_o, ones_o} !== 8'h02 || running_o !== 1'b0) begin
      bad++;
      $display("FAIL pause_enter got=%h run=%b want=02 run=0", {tens_o, ones_o}, running_o);
    end
    cyc(20);
    total++;
    if ({tens_o, ones_o} !== 8'h02) begin
      bad++;
      $display("FAIL pause_hold got=%h want=02", {tens_o, ones_o});
    end
    pulse(1'b1, 1'b0, 1'b0);
    total++;
    if (running_o !== 1'b1 || {tens_o, ones_o} !== 8'h02) begin
      bad++;
      $display("FAIL resume got=%h run=%b want=02 run=1", {tens_o, ones_o}, running_o);
    end
    cyc(2);
    total++;
    if ({tens_o, ones_o} !== 8'h02) begin
      bad++;
      $display("FAIL resume_e32 got=%h want=02", {tens_o, ones_o});
    end
    cyc(1);
    total++;
    if ({tens_o, ones_o} !== 8'h03) begin
      bad++;
      $display("FAIL resume_e33 got=%h want=03", {tens_o, ones_o});
    end
    pulse(1'b0, 1'b0, 1'b1);
  endtask
  task automatic test_clear_start;
    pulse(1'b1, 1'b0, 1'b0);
    cyc(20);
    total++;
    if ({tens_o, ones_o} !== 8'h05) begin
      bad++;
      $display("FAIL pre_clear got=%h want=05", {tens_o, ones_o});
    end
    pulse(1'b1, 1'b0, 1'b1);
    total++;
    if ({tens_o, ones_o} !== 8'h00 || running_o !== 1'b0) begin
      bad++;
      $display("FAIL clear_start got=%h run=%b want=00 run=0", {tens_o, ones_o}, running_o);
    end
    cyc(8);
    total++;
    if ({tens_o, ones_o} !== 8'h00) begin
      bad++;
      $display("FAIL clear_idle got=%h want=00", {tens_o, ones_o});
    end
  endtask
  task automatic test_stop_on_tick;
    pulse(1'b1, 1'b0, 1'b0);
    cyc(47);
    total++;
    if ({tens_o, ones_o} !== 8'h11) begin
      bad++;
      $display("FAIL pre_stop_tick got=%h want=11", {tens_o, ones_o});
    end
    pulse(1'b0, 1'b1, 1'b0);
    total++;
    if ({tens_o, ones_o} !== 8'h12 || done_o !== 1'b1 || running_o !== 1'b0) begin
      bad++;
      $display("FAIL stop_tick_done got=%h done=%b run=%b want=12 done=1 run=0", {tens_o, ones_o}, done_o, running_o);
    end
    pulse(1'b1, 1'b1, 1'b0);
    total++;
    if (running_o !== 1'b0 || {tens_o, ones_o} !== 8'h12) begin
      bad++;
      $display("FAIL stop_over_start got=%h run=%b want=12 run=0", {tens_o, ones_o}, running_o);
    end
    pulse(1'b0, 1'b0, 1'b1);
  endtask
  task automatic test_async_reset;
    pulse(1'b1, 1'b0, 1'b0);
    cyc(22);
    total++;
    if ({tens_o, ones_o} !== 8'h05 || running_o !== 1'b1) begin
      bad++;
      $display("FAIL pre_rst got=%h run=%b want=05 run=1", {tens_o, ones_o}, running_o);
    end
    rst_i = 1'b1;
    #2;
    total++;
    if ({tens_o, ones_o} !== 8'h00 || running_o !== 1'b0) begin
      bad++;
      $display("FAIL async_rst got=%h run=%b want=00 run=0", {tens_o, ones_o}, running_o);
    end
    rst_i = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    total++;
    if ({tens_o, ones_o} !== 8'h00 || running_o !== 1'b1) begin
      bad++;
      $display("FAIL rst_restart got=%h run=%b want=00 run=1", {tens_o, ones_o}, running_o);
    end
    cyc(4);
    total++;
    if ({tens_o, ones_o} !== 8'h01) begin
      bad++;
      $display("FAIL rst_restart_step got=%h want=01", {tens_o, ones_o});
    end
    pulse(1'b0, 1'b0, 1'b1);
  endtask
  task automatic test_direction;
    logic [7:0] w0, w4, w12, w48;
`ifdef COUNT_SEQ_DOWN_EN
    w0 = 8'h12; w4 = 8'h11; w12 = 8'h09; w48 = 8'h00;
`else
    w0 = 8'h00; w4 = 8'h01; w12 = 8'h03; w48 = 8'h12;
`endif
    dir_i = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
    total++;
    if ({tens_o, ones_o} !== w0) begin
      bad++;
      $display("FAIL dir_e0 got=%h want=%h", {tens_o, ones_o}, w0);
    end
    dir_i = 1'b0;
    cyc(4);
    total++;
    if ({tens_o, ones_o} !== w4) begin
      bad++;
      $display("FAIL dir_e4 got=%h want=%h", {tens_o, ones_o}, w4);
    end
    cyc(8);
    total++;
    if ({tens_o, ones_o} !== w12) begin
      bad++;
      $display("FAIL dir_e12 got=%h want=%h", {tens_o, ones_o}, w12);
    end
    cyc(36);
    total++;
    if ({tens_o, ones_o} !== w48 || done_o !== 1'b1 || running_o !== 1'b0) begin
      bad++;
      $display("FAIL dir_e48 got=%h done=%b run=%b want=%h done=1 run=0", {tens_o, ones_o}, done_o, running_o, w48);
    end
  endtask
  initial begin
    test_reset;
    test_count_up;
    test_restart_from_done;
    test_pause;
    test_clear_start;
    test_stop_on_tick;
    test_async_reset;
    test_direction;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
